hamming74_uart_tx: RTL
======================

# hamming74_uart_tx

Transmit-side counterpart of the UART/Hamming(7,4) receive chain. Accepts 4-bit data nibbles through a valid/ready handshake and buffers them in a small FIFO. Encodes each nibble into a 7-bit Hamming(7,4) code word and serialises it as a UART frame whose format matches what the receiver expects. The block drives the serial line that feeds the receiver's `rx` input, in loopback tests or from a peer chip.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: nibble FIFO entries; must be a power of 2 and ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous assertion, active-low.
- `ena`  input  1  when low, no new frame starts; a frame already in flight completes.
- `data_in`  input  4  nibble to transmit.
- `data_valid`  input  1  `data_in` is valid this cycle.
- `data_ready`  output  1  FIFO can accept a nibble; equals `!full`.
- `tx`  output  1  registered UART serial output; idles high.
- `code_out`  output  7  code word of the frame most recently loaded.
- `busy`  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- `frame_done`  output  1  one-cycle pulse on the last cycle of each stop bit.
- `inj_pos`  input  3  error-injection position; present only with `HAMMING_TX_ERR_INJECT_EN`.

## Operation
- Reset values: `tx`=1, `data_ready`=1, `code_out`=0, `busy`=0, `frame_done`=0, FSM=IDLE, FIFO empty.
- **Push:** a nibble is written when `data_valid && data_ready` at a rising edge. Writes while full are impossible, because `data_ready` is low.
- **No bypass:** a nibble written at edge E is first visible to the FSM after E.
- **Same-cycle push and pop:** count is unchanged; both pointers advance; pointers wrap modulo `FIFO_DEPTH`.
- **Encoding:** input d = `data_in`; the code word is assembled as follows.
  - Data bits: `code[2]`=d0, `code[4]`=d1, `code[5]`=d2, `code[6]`=d3.
  - `code[0]` = d0^d1^d3.
  - `code[1]` = d0^d2^d3.
  - `code[3]` = d1^d2^d3.
- **Frame format:** start bit (0), then `code[0]`..`code[6]` LSB first, then one stop bit (1). A frame is 9×`CLKS_PER_BIT` cycles.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START: when `ena` is high and the FIFO is not empty. On that edge the FSM pops, encodes, loads the shift register and `code_out`, and drives `tx`=0.
  - START → DATA: after `CLKS_PER_BIT` cycles; `tx` = `code[0]`.
  - DATA: shifts one bit every `CLKS_PER_BIT` cycles. After the 7th bit completes, moves to STOP with `tx`=1.
  - STOP end: `frame_done` pulses. If `ena` is high and the FIFO is not empty, the FSM goes directly to START and pops; the next start bit follows with no idle gap. Otherwise it returns to IDLE.
- **Counters:** the bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide and the bit index is 3 bits wide. Both reset at every state entry.
- **`ena` deassertion:** mid-frame, the frame completes normally. `ena` only gates frame starts.
- **Reset mid-frame:** `tx` goes to 1 immediately (asynchronously), the FIFO contents are discarded, and the FSM returns to IDLE.

## Timing
- Accept-to-start latency: with an empty FIFO and the FSM idle, a nibble accepted at edge E produces `tx` falling after edge E+1.
- Every bit lasts exactly `CLKS_PER_BIT` cycles, measured at `tx`.
- `frame_done` is high for the single cycle before the STOP→next transition.
- `busy` falls in the cycle after the final `frame_done`, provided the FIFO is empty.
- Sustained throughput: one frame per 9×`CLKS_PER_BIT` cycles.

## Configuration
- Macro: `HAMMING_TX_ERR_INJECT_EN`.
- **Defined:** the `inj_pos` port exists. When `inj_pos` = k, with k in 1..7, code bit k−1 is inverted at load time. Both `code_out` and the transmitted bits carry the inverted bit. `inj_pos`=0 leaves the word unmodified.
- **Undefined:** the port is absent and code words are always correct.

## Test plan
- Reset: hold `rst_n` low → `tx`=1, `data_ready`=1, `busy`=0, `code_out`=0; these values hold after release with no input.
- Single nibble 4'hB, `CLKS_PER_BIT`=16 → `code_out`=7'h55; `tx` is 0 then 1,0,1,0,1,0,1 then 1, 16 cycles per bit; `frame_done` pulses once at cycle 144 after start.
- Encoding corners: 4'h0 → 7'h00; 4'hF → 7'h7F; 4'h1 → 7'h07.
- FIFO full: hold `ena`=0 and push 4 nibbles 1,2,3,4 → `data_ready` goes low after the 4th push. Then raise `ena` → 4 frames in order, back-to-back over 576 cycles with no idle-high gap, then `busy`=0.
- Reset mid-frame: assert `rst_n` low during data bit 3 of a frame with 2 nibbles queued → `tx`=1 immediately, `busy`=0, and nothing is sent after release.
- With `HAMMING_TX_ERR_INJECT_EN`: `inj_pos`=3 and nibble 4'hB → `code_out`=7'h51, and the transmitted bits match 7'h51.

Source files
------------

// File: rtl/hamming74_uart_tx.sv
// hamming74_uart_tx: FIFO-buffered Hamming(7,4) encoder driving a UART 8N1-style serial line (7 code bits).
// Optional HAMMING_TX_ERR_INJECT_EN adds inj_pos to flip one code bit at load time.
module hamming74_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [2:0] inj_pos,
`endif
  output logic       data_ready,
  output logic       tx,
  output logic [6:0] code_out,
  output logic       busy,
  output logic       frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [6:0] sh, word, inj;
  logic push, start, bit_end, empty;
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
  always_comb begin
    empty = count == '0;
    data_ready = count != (AW+1)'(FIFO_DEPTH);
    push = data_valid && data_ready;
    bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    start = ena && !empty && (state == IDLE || (state == STOP && bit_end));
`ifdef HAMMING_TX_ERR_INJECT_EN
    inj = (inj_pos == 3'd0) ? 7'd0 : 7'd1 << (inj_pos - 3'd1);
`else
    inj = 7'd0;
`endif
    word = enc(mem[rd_ptr]) ^ inj;
    busy = state != IDLE || !empty;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (start) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, start};
    end
  // Pop, encode and load happen on the same edge that drives the start bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx <= 1'b1;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      code_out <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == STOP && cnt == CW'(CLKS_PER_BIT - 2);
      if (start) begin
        state <= START;
        cnt <= '0;
        idx <= '0;
        tx <= 1'b0;
        sh <= word;
        code_out <= word;
      end else begin
        case (state)
          START: if (bit_end) begin
            state <= DATA;
            cnt <= '0;
            idx <= '0;
            tx <= sh[0];
            sh <= sh >> 1;
          end else cnt <= cnt + 1'b1;
          DATA: if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd6) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx <= sh[0];
              sh <= sh >> 1;
            end
          end else cnt <= cnt + 1'b1;
          STOP: if (bit_end) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
          default: ;
        endcase
      end
    end
endmodule
